// File: rtl/decode_issue.sv
// decode_issue: decodes instructions into one ID/EX slot, reads a bypassed register file,
// and stalls RAW hazards using a pending-write scoreboard.
module decode_issue #(
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [5:0]        ex_alu_control,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_wr_en,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              illegal
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [DATA_W-1:0]   rf_q [RF_DEPTH];
    logic [RF_DEPTH-1:0] pend_q, pend_d;
    logic [5:0]          alu_q, alu_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [4:0]          rd_q, rd_d;
    logic                wr_q, wr_d, mrd_q, mrd_d, mwr_q, mwr_d, ill_q, ill_d;
    logic [5:0]          op;
    logic [4:0]          rd, rs, rt;
    logic                legal, use_a, use_b, wr, hazard, accept;
    logic [DATA_W-1:0]   opa, opb;

    assign op = in_instr[31:26];
    assign rd = in_instr[25:21];
    assign rs = in_instr[20:16];
    assign rt = in_instr[15:11];

    always_comb begin
        legal    = op <= 6'd4;
        use_a    = legal && op != 6'd0;
        use_b    = op == 6'd1 || op == 6'd2 || op == 6'd3;
        wr       = (op == 6'd1 || op == 6'd2 || op == 6'd4) && rd != 5'd0;
        // a writeback landing this cycle resolves the hazard through the bypass
        hazard   = (use_a && rs != 5'd0 && pend_q[rs] && !(wb_en && wb_addr == rs)) ||
                   (use_b && rt != 5'd0 && pend_q[rt] && !(wb_en && wb_addr == rt));
        in_ready = (state_q == EMPTY || ex_ready) && !hazard;
        accept   = in_valid && in_ready;
        opa      = (!use_a || rs == 5'd0) ? '0 : (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
        opb      = (!use_b || rt == 5'd0) ? '0 : (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
        state_d  = accept ? FULL : ex_ready ? EMPTY : state_q;
        pend_d   = pend_q;
        if (wb_en)
            pend_d[wb_addr] = 1'b0;
        if (accept && wr)
            pend_d[rd] = 1'b1;
        alu_d    = accept ? (legal ? op : 6'd0) : alu_q;
        a_d      = accept ? opa : a_q;
        b_d      = accept ? opb : b_q;
        imm_d    = accept ? (legal ? {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]} : '0) : imm_q;
        rd_d     = accept ? (legal ? rd : 5'd0) : rd_q;
        wr_d     = accept ? wr : wr_q;
        mrd_d    = accept ? op == 6'd4 : mrd_q;
        mwr_d    = accept ? op == 6'd3 : mwr_q;
        ill_d    = accept && !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pend_q  <= '0;
            alu_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            ill_q   <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++)
                rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            alu_q   <= alu_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            ill_q   <= ill_d;
            if (wb_en && wb_addr != 5'd0)
                rf_q[wb_addr] <= wb_data;
        end
    end

    assign ex_valid       = state_q == FULL;
    assign ex_alu_control = alu_q;
    assign ex_a           = a_q;
    assign ex_b           = b_q;
    assign ex_imm         = imm_q;
    assign ex_rd          = rd_q;
    assign ex_wr_en       = wr_q;
    assign ex_mem_rd      = mrd_q;
    assign ex_mem_wr      = mwr_q;
    assign illegal        = ill_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: table-driven decode vectors plus hand-written stall, hold, illegal and
// reset sequences; issued instructions are scoreboarded and compared when the slot drains.
module tb_decode_issue;
    typedef struct packed {
        logic [5:0]  alu;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic        wr, mrd, mwr, ill;
    } exp_t;
    typedef struct {
        logic [31:0] ins;
        exp_t        e;
    } vec_t;

    logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, wb_en = 0, ex_valid, ex_ready = 0;
    logic [31:0] in_instr = 0, wb_data = 0, ex_a, ex_b, ex_imm;
    logic [4:0]  wb_addr = 0, ex_rd;
    logic [5:0]  ex_alu_control;
    logic        ex_wr_en, ex_mem_rd, ex_mem_wr, illegal;

    int   tests = 0, fails = 0;
    exp_t q[$];
    exp_t cur_e;
    logic accepted = 0;
    vec_t tbl[9];

    decode_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_alu_control(ex_alu_control), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, rs, rt,
                                       input logic [10:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    function automatic exp_t ex(input logic [5:0] alu, input logic [31:0] a, b, imm,
                                input logic [4:0] rd, input logic wr, mrd, mwr, ill);
        exp_t e;
        e = '{alu, a, b, imm, rd, wr, mrd, mwr, ill};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // observe at the negative edge: score the slot being consumed, then record an accept
    task automatic mon();
        exp_t got, e;
        accepted = 0;
        if (ex_valid && ex_ready) begin
            got = {ex_alu_control, ex_a, ex_b, ex_imm, ex_rd, ex_wr_en, ex_mem_rd, ex_mem_wr, illegal};
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got alu=%0d a=%h b=%h expected no output",
                         got.alu, got.a, got.b);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL sb_out: got alu=%0d a=%h b=%h imm=%h rd=%0d wr=%b mrd=%b mwr=%b ill=%b expected alu=%0d a=%h b=%h imm=%h rd=%0d wr=%b mrd=%b mwr=%b ill=%b",
                             got.alu, got.a, got.b, got.imm, got.rd, got.wr, got.mrd, got.mwr, got.ill,
                             e.alu, e.a, e.b, e.imm, e.rd, e.wr, e.mrd, e.mwr, e.ill);
                end
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(cur_e);
            accepted = 1;
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input exp_t e);
        int n = 0;
        in_valid = 1;
        in_instr = ins;
        cur_e = e;
        nxt();
        while (!accepted && n < 50) begin
            n++;
            nxt();
        end
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
        end
        in_valid = 0;
    endtask

    task automatic wb(input logic [4:0] adr, input logic [31:0] d);
        wb_en = 1;
        wb_addr = adr;
        wb_data = d;
        nxt();
        wb_en = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_valid = 0;
        wb_en = 0;
        ex_ready = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        tbl[0] = '{mk(1, 20, 1, 2, 0),       ex(1, 5, 3, 32'h1000, 20, 1, 0, 0, 0)};
        tbl[1] = '{mk(2, 21, 5, 7, 11'h7FF), ex(2, 100, 7, 32'h3FFF, 21, 1, 0, 0, 0)};
        tbl[2] = '{mk(3, 22, 6, 1, 11'h004), ex(3, 32'hFFFF_FFF0, 5, 32'h0804, 22, 0, 0, 1, 0)};
        tbl[3] = '{mk(4, 23, 5, 31, 11'h7FC), ex(4, 100, 0, 32'hFFFF_FFFC, 23, 1, 1, 0, 0)};
        tbl[4] = '{mk(0, 0, 1, 0, 0),        ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{mk(1, 0, 0, 7, 0),        ex(1, 0, 7, 32'h3800, 0, 0, 0, 0, 0)};
        tbl[6] = '{mk(7, 0, 1, 0, 0),        ex(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[7] = '{mk(1, 27, 2, 2, 11'h400), ex(1, 3, 3, 32'h1400, 27, 1, 0, 0, 0)};
        tbl[8] = '{mk(63, 0, 0, 0, 0),       ex(0, 0, 0, 0, 0, 0, 0, 0, 1)};

        #3;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_outputs", {ex_alu_control, ex_a, ex_wr_en, illegal}, 0);
        do_reset();
        chk("rst_in_ready", in_ready, 1);

        // decode table, issued back to back
        wb(1, 5); wb(2, 3); wb(5, 100); wb(6, 32'hFFFF_FFF0); wb(7, 7);
        ex_ready = 1;
        foreach (tbl[i]) send(tbl[i].ins, tbl[i].e);
        repeat (2) nxt();
        chk("table_drained", q.size(), 0);

        // basic ADD and pending bit
        do_reset();
        wb(1, 5); wb(2, 3);
        ex_ready = 1;
        send(mk(1, 3, 1, 2, 0), ex(1, 5, 3, 32'h1000, 3, 1, 0, 0, 0));
        chk("pend3_set", dut.pend_q[3], 1);
        nxt();

        // RAW stall on LOAD destination, released by writeback with bypass
        send(mk(4, 4, 0, 31, 11'h7FC), ex(4, 0, 0, 32'hFFFF_FFFC, 4, 1, 1, 0, 0));
        in_valid = 1;
        in_instr = mk(1, 5, 4, 1, 0);
        cur_e = ex(1, 9, 5, 32'h0800, 5, 1, 0, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("raw_stall_ready", in_ready, 0);
            nxt();
            chk("raw_stall_noaccept", accepted, 0);
        end
        wb_en = 1; wb_addr = 4; wb_data = 9;
        #1;
        chk("raw_release_ready", in_ready, 1);
        nxt();
        chk("raw_release_accept", accepted, 1);
        wb_en = 0;
        in_valid = 0;
        chk("pend4_cleared", dut.pend_q[4], 0);
        repeat (2) nxt();

        // slot held under back-pressure, then back-to-back issue
        ex_ready = 0;
        send(mk(1, 6, 1, 2, 0), ex(1, 5, 3, 32'h1000, 6, 1, 0, 0, 0));
        in_valid = 1;
        in_instr = mk(2, 7, 2, 1, 0);
        cur_e = ex(2, 3, 5, 32'h0800, 7, 1, 0, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("hold_ready", in_ready, 0);
            chk("hold_payload", {ex_valid, ex_alu_control, ex_a, ex_b, ex_rd}, {1'b1, 6'd1, 32'd5, 32'd3, 5'd6});
            nxt();
        end
        ex_ready = 1;
        nxt();
        chk("b2b_accept", accepted, 1);
        in_valid = 0;
        nxt();
        nxt();
        chk("b2b_empty", ex_valid, 0);

        // illegal opcode pulses exactly one cycle
        send(mk(7, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("illegal_pulse", illegal, 1);
        nxt();
        chk("illegal_clear", illegal, 0);

        // R0 is never written and never pending
        wb(0, 77);
        send(mk(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("pend0_clear", dut.pend_q[0], 0);
        nxt();

        // asynchronous reset while the slot is full
        ex_ready = 0;
        send(mk(1, 8, 1, 2, 0), ex(1, 5, 3, 32'h1000, 8, 1, 0, 0, 0));
        chk("full_before_reset", ex_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_pend", dut.pend_q, 0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        chk("reset_ready", in_ready, 1);
        ex_ready = 1;
        send(mk(1, 9, 1, 2, 0), ex(1, 0, 0, 32'h1000, 9, 1, 0, 0, 0));
        repeat (2) nxt();
        chk("final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
